conv_frame_sequencer: RTL

Frame-level controller for the 3x3 Sobel convolution datapath. It tracks raster position and qualifies the line-buffer clock enable. It flags when a full 3x3 window is valid, latches the kernel selection once per frame, and aligns an output-valid strobe with the datapath's fixed pipeline latency. It sits between the sensor/raw-data front end and the convolution datapath, replacing ad-hoc edge checks on external X/Y counters.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/valid_delay_line.sv | 24 ++
 rtl/conv_frame_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution frame control path.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KSEL_BYPASS = 2'd0,
        KSEL_VERT   = 2'd1,
        KSEL_HORIZ  = 2'd2
    } ksel_t;

    localparam int DEF_IMG_W    = 1280;
    localparam int DEF_IMG_H    = 1024;
    localparam int DEF_PIPE_LAT = 3;

    // The reserved encoding falls back to the vertical kernel.
    function automatic ksel_t map_ksel(input logic [1:0] k);
        ksel_t r;
        case (k)
            2'd0:    r = KSEL_BYPASS;
            2'd2:    r = KSEL_HORIZ;
            default: r = KSEL_VERT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid-bit shift register with synchronous clear; output lags input by DEPTH cycles.
module valid_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_sh;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sh <= '0;
        end else begin
            r_sh <= (r_sh << 1) | DEPTH'(i_vld);
        end
    end

    assign o_vld = r_sh[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Raster-position tracker and window/result-valid sequencer for the 3x3 Sobel datapath.
// Kernel select is latched per frame; oDVAL trails oWIN_VALID by PIPE_LAT cycles.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int CW       = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSOF,
    input  logic          iDVAL,
    input  logic [1:0]    iKSEL,
    output logic [CW-1:0] oX_Cont,
    output logic [CW-1:0] oY_Cont,
    output logic          oLB_EN,
    output logic          oWIN_VALID,
    output logic [1:0]    oKSEL,
    output logic          oDVAL,
    output logic          oEOF,
    output logic          oBUSY,
    output logic          oERR
);

    localparam int            FW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [FW-1:0] FLAST = FW'(PIPE_LAT - 1);
    localparam logic [CW-1:0] XMAX  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] YMAX  = CW'(IMG_H - 1);

    state_t        r_state, w_next;
    ksel_t         r_ksel;
    logic [CW-1:0] r_x, r_y, r_nx, r_ny, w_px, w_py;
    logic [FW-1:0] r_fcnt;
    logic          r_pend, r_winv, r_eof, r_err;
    logic          w_in_frame, w_sof_idle, w_abort, w_flush_done, w_start, w_acc;

    assign w_in_frame   = (r_state == FILL) || (r_state == ACTIVE);
    assign w_sof_idle   = iSOF && (r_state == IDLE);
    assign w_abort      = iSOF && w_in_frame;
    assign w_flush_done = (r_state == FLUSH) && (r_fcnt == FLAST);
    assign w_start      = w_sof_idle || w_abort || (w_flush_done && (r_pend || iSOF));
    assign w_acc        = iDVAL && (w_in_frame || w_sof_idle);

    // A pixel arriving with iSOF is always the frame origin.
    assign w_px = (w_sof_idle || w_abort) ? '0 : r_nx;
    assign w_py = (w_sof_idle || w_abort) ? '0 : r_ny;

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (iSOF) w_next = FILL;
            FILL: begin
                if (w_abort) w_next = FILL;
                else if (w_acc && w_px == XMAX && w_py == CW'(1)) w_next = ACTIVE;
            end
            ACTIVE: begin
                if (w_abort) w_next = FILL;
                else if (w_acc && w_px == XMAX && w_py == YMAX) w_next = FLUSH;
            end
            FLUSH:  if (w_flush_done) w_next = w_start ? FILL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_ksel <= KSEL_BYPASS;
            r_x    <= '0;
            r_y    <= '0;
            r_nx   <= '0;
            r_ny   <= '0;
            r_fcnt <= '0;
            r_pend <= 1'b0;
            r_winv <= 1'b0;
            r_eof  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_eof  <= w_flush_done;
            r_err  <= r_err | w_abort;
            r_winv <= w_acc && (w_px >= CW'(2)) && (w_py >= CW'(2));
            r_fcnt <= (r_state == FLUSH) ? r_fcnt + FW'(1) : '0;
            if (w_flush_done)                   r_pend <= 1'b0;
            else if (r_state == FLUSH && iSOF)  r_pend <= 1'b1;
            if (w_start) begin
                r_ksel <= map_ksel(iKSEL);
                r_x    <= '0;
                r_y    <= '0;
                r_nx   <= '0;
                r_ny   <= '0;
            end
            if (w_acc) begin
                r_x  <= w_px;
                r_y  <= w_py;
                r_nx <= (w_px == XMAX) ? '0 : w_px + CW'(1);
                r_ny <= (w_px != XMAX) ? w_py : ((w_py == YMAX) ? w_py : w_py + CW'(1));
            end
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_clr (w_abort),
        .i_vld (r_winv),
        .o_vld (oDVAL)
    );

    assign oX_Cont    = r_x;
    assign oY_Cont    = r_y;
    assign oLB_EN     = w_acc;
    assign oWIN_VALID = r_winv;
    assign oKSEL      = r_ksel;
    assign oEOF       = r_eof;
    assign oBUSY      = (r_state != IDLE);
    assign oERR       = r_err;

endmodule
